fetch_id: RTL and testbench
===========================

Name: fetch_id

Overview:
- Pipeline register between the fetch stage and the decode (id) stage.
- Captures the fetched instruction and its PC on a valid/ready handshake and presents them to id.
- Two-entry skid buffer: this_ready is a registered signal, so id backpressure never combinationally reaches fetch/AXI R channel.
- flush input discards all buffered instructions on a control-flow redirect.

Parameters:
- ADDR_WIDTH, 32, width of PC (matches INST_ADDR_BUS)
- DATA_WIDTH, 32, width of instruction word (matches INST_DATA_BUS)

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  drop all held entries; one-cycle pulse from redirect logic
- pc_in  input  ADDR_WIDTH  PC of incoming instruction (from fetch)
- inst_in  input  DATA_WIDTH  incoming instruction (fetch R data)
- prev_valid  input  1  fetch has a valid instruction
- this_ready  output  1  buffer can accept (to fetch, drives rready)
- next_ready  input  1  id accepts
- this_valid  output  1  instruction valid to id
- pc_out  output  ADDR_WIDTH  PC to id
- inst_out  output  DATA_WIDTH  instruction to id

Behaviour:
- Clock/reset: one clock (clk); rst_n is asynchronous, active-low.
- Reset: main_valid=0, skid_valid=0, main/skid pc and inst = 0. Outputs are this_valid=0, this_ready=1, pc_out=0, inst_out=0.
- Combinational outputs:
  - this_ready = !skid_valid (register-derived only).
  - this_valid = main_valid.
  - pc_out/inst_out = main entry.
- Handshakes: in_fire = prev_valid & this_ready; out_fire = this_valid & next_ready.
- States: EMPTY (no valid entry), ONE (main valid), TWO (main+skid valid).
- EMPTY:
  - in_fire -> ONE, main <= in.
- ONE:
  - in_fire & out_fire -> ONE, main <= in.
  - in_fire & !out_fire -> TWO, skid <= in.
  - !in_fire & out_fire -> EMPTY.
  - else hold.
- TWO (this_ready=0):
  - out_fire -> ONE, main <= skid, skid_valid <= 0.
  - else hold.
- Latency: input accepted at edge N appears on outputs after edge N. There is no same-cycle bypass.
- Ordering: strictly FIFO; skid entry always older than any later input.
- Stability: while this_valid & !next_ready, pc_out/inst_out must not change.
- flush: highest priority. Next state is EMPTY regardless of in_fire/out_fire; an instruction handshaken in the flush cycle is discarded. this_ready during the flush cycle still follows skid_valid.
- Data registers are not cleared on flush (only valids); values when invalid are don't-care except after reset.
- Asserting rst_n low mid-transfer clears both entries immediately (async). The first accept after deassertion is allowed on the next edge.

Optional Feature:
- Macro FETCH_ID_PERF_EN.
- Defined:
  - Adds outputs perf_fire_cnt[31:0] (count of out_fire cycles) and perf_stall_cnt[31:0] (count of cycles with this_valid & !next_ready).
  - Both counters are reset to 0 by rst_n, are not cleared by flush, and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> this_valid=0, this_ready=1, pc_out=0, inst_out=0.
- Streaming:
  - Stimulus: prev_valid=1 and next_ready=1 continuously; pc_in 0x8000_0000, +4 per cycle; inst_in 0x0000_0013.
  - Required: each pc appears on pc_out exactly one cycle later; this_ready stays 1; no drops or duplicates.
- Backpressure:
  - Stimulus: accept pc 0x8000_0000, then 0x8000_0004, with next_ready=0.
  - Required: state TWO and this_ready=0 the following cycle, pc_out held at 0x8000_0000. Release next_ready to see 0x8000_0000 then 0x8000_0004, with this_ready returning to 1 after the first out_fire.
- Flush in TWO with simultaneous prev_valid=1 (pc 0x8000_0008) -> next cycle this_valid=0, this_ready=1. 0x8000_0008 never appears at the output.
- Async reset asserted in ONE mid-cycle -> this_valid drops to 0 before the next clk edge.
- With FETCH_ID_PERF_EN:
  - Stimulus: 5 transfers with 3 cycles of next_ready=0 while valid.
  - Required: perf_fire_cnt=5, perf_stall_cnt=3. A counter preloaded via force to 0xFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/fetch_id.sv
// Fetch-to-decode pipeline register: a two-entry skid buffer whose ready output comes only from registers.
// Optional FETCH_ID_PERF_EN adds out_fire and stall event counters.
module fetch_id #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] inst_in,
    input  logic                  prev_valid,
    output logic                  this_ready,
    input  logic                  next_ready,
    output logic                  this_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] inst_out
`ifdef FETCH_ID_PERF_EN
    ,
    output logic [31:0]           perf_fire_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] main_pc_q;
    logic [DATA_WIDTH-1:0] main_inst_q;
    logic [ADDR_WIDTH-1:0] skid_pc_q;
    logic [DATA_WIDTH-1:0] skid_inst_q;
    logic                  in_fire;
    logic                  out_fire;

    // Ready is taken from state alone so id backpressure never reaches fetch combinationally
    assign this_ready = (state_q != TWO);
    assign this_valid = (state_q != EMPTY);
    assign pc_out     = main_pc_q;
    assign inst_out   = main_inst_q;
    assign in_fire    = prev_valid & this_ready;
    assign out_fire   = this_valid & next_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else if (flush) begin
            // Redirect drops every held entry; data registers keep stale values
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q     <= ONE;
                        main_pc_q   <= pc_in;
                        main_inst_q <= inst_in;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_pc_q   <= pc_in;
                        main_inst_q <= inst_in;
                    end else if (in_fire) begin
                        state_q     <= TWO;
                        skid_pc_q   <= pc_in;
                        skid_inst_q <= inst_in;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_q     <= ONE;
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef FETCH_ID_PERF_EN
    logic [31:0] perf_fire_cnt_q;
    logic [31:0] perf_stall_cnt_q;

    // Event counters survive flush and wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fire_cnt_q  <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            if (out_fire) begin
                perf_fire_cnt_q <= perf_fire_cnt_q + 32'd1;
            end
            if (this_valid && !next_ready) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fire_cnt  = perf_fire_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_id.sv
// Directed self-checking bench for fetch_id; define FETCH_ID_PERF_EN to also cover the perf counters.
module tb_fetch_id;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] pc_in;
    logic [DATA_WIDTH-1:0] inst_in;
    logic                  prev_valid;
    logic                  this_ready;
    logic                  next_ready;
    logic                  this_valid;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] inst_out;
`ifdef FETCH_ID_PERF_EN
    logic [31:0]           perf_fire_cnt;
    logic [31:0]           perf_stall_cnt;
`endif

    int n_checks;
    int n_errors;

    fetch_id #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .pc_in         (pc_in),
        .inst_in       (inst_in),
        .prev_valid    (prev_valid),
        .this_ready    (this_ready),
        .next_ready    (next_ready),
        .this_valid    (this_valid),
        .pc_out        (pc_out),
        .inst_out      (inst_out)
`ifdef FETCH_ID_PERF_EN
        ,
        .perf_fire_cnt (perf_fire_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic nr, input logic [31:0] pc);
        prev_valid = pv;
        next_ready = nr;
        pc_in      = pc;
        inst_in    = NOP;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        drive(1'b0, 1'b0, 32'h0);

        // Reset and idle
        #12;
        check_eq("rst_valid", 64'(this_valid), 64'd0);
        check_eq("rst_ready", 64'(this_ready), 64'd1);
        check_eq("rst_pc",    64'(pc_out),     64'd0);
        check_eq("rst_inst",  64'(inst_out),   64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_valid", 64'(this_valid), 64'd0);
        check_eq("idle_ready", 64'(this_ready), 64'd1);

        // Streaming: each pc shows up one edge after it is offered
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 32'h8000_0000 + 32'(i * 4));
            tick();
            check_eq($sformatf("stream_pc%0d", i), 64'(pc_out), 64'(32'h8000_0000 + 32'(i * 4)));
            check_eq($sformatf("stream_rdy%0d", i), 64'(this_ready), 64'd1);
            check_eq($sformatf("stream_vld%0d", i), 64'(this_valid), 64'd1);
        end
        check_eq("stream_inst", 64'(inst_out), 64'(NOP));
        drive(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("stream_drain", 64'(this_valid), 64'd0);

        // Backpressure fills the skid entry
        drive(1'b1, 1'b0, 32'h8000_0000);
        tick();
        check_eq("bp_one_pc", 64'(pc_out), 64'h8000_0000);
        drive(1'b1, 1'b0, 32'h8000_0004);
        tick();
        check_eq("bp_two_ready", 64'(this_ready), 64'd0);
        check_eq("bp_two_pc",    64'(pc_out),     64'h8000_0000);
        drive(1'b1, 1'b0, 32'h8000_00FC);
        tick();
        check_eq("bp_hold_pc",    64'(pc_out),     64'h8000_0000);
        check_eq("bp_hold_ready", 64'(this_ready), 64'd0);
        drive(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("bp_rel_pc",    64'(pc_out),     64'h8000_0004);
        check_eq("bp_rel_ready", 64'(this_ready), 64'd1);
        check_eq("bp_rel_valid", 64'(this_valid), 64'd1);
        tick();
        check_eq("bp_empty", 64'(this_valid), 64'd0);

        // Flush in TWO while fetch offers 0x8000_0008
        drive(1'b1, 1'b0, 32'h8000_0010);
        tick();
        drive(1'b1, 1'b0, 32'h8000_0014);
        tick();
        check_eq("fl_two_ready", 64'(this_ready), 64'd0);
        drive(1'b1, 1'b0, 32'h8000_0008);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_two_valid", 64'(this_valid), 64'd0);
        check_eq("fl_two_ready", 64'(this_ready), 64'd1);
        drive(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("fl_two_after", 64'(this_valid), 64'd0);

        // Flush in ONE discards an instruction handshaken in the same cycle
        drive(1'b1, 1'b0, 32'h8000_0020);
        tick();
        drive(1'b1, 1'b0, 32'h8000_0008);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_one_valid", 64'(this_valid), 64'd0);
        drive(1'b1, 1'b1, 32'h8000_0030);
        tick();
        check_eq("fl_one_next", 64'(pc_out), 64'h8000_0030);
        drive(1'b0, 1'b1, 32'h0);
        tick();

        // Async reset mid-cycle while holding an entry
        drive(1'b1, 1'b0, 32'h8000_0040);
        tick();
        check_eq("ar_pre_valid", 64'(this_valid), 64'd1);
        drive(1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_valid", 64'(this_valid), 64'd0);
        check_eq("ar_ready", 64'(this_ready), 64'd1);
        check_eq("ar_pc",    64'(pc_out),     64'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h8000_0044);
        tick();
        check_eq("ar_accept", 64'(pc_out), 64'h8000_0044);
        drive(1'b0, 1'b1, 32'h0);
        tick();

`ifdef FETCH_ID_PERF_EN
        // Fresh reset, then 5 transfers with 3 stall cycles
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h8000_0100);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h8000_0100 + 32'(i * 4));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        drive(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("perf_fire",  64'(perf_fire_cnt),  64'd5);
        check_eq("perf_stall", 64'(perf_stall_cnt), 64'd3);
        drive(1'b1, 1'b0, 32'h8000_0200);
        tick();
        force dut.perf_fire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_fire_cnt_q;
        drive(1'b0, 1'b1, 32'h0);
        tick();
        check_eq("perf_wrap", 64'(perf_fire_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
